// File: rtl/countdown16.sv
// Loadable 16-bit down counter built from four 4-bit nibbles with registered
// borrow flags; one-shot or auto-reload, with a one-clock terminal-count pulse.
module countdown16 #(
  parameter bit          AUTO_RELOAD = 1'b0,
  parameter logic [15:0] RESET_VALUE = 16'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [15:0] i_value,
  input  logic        i_en,
  input  logic        i_stop,
  output logic [15:0] q,
  output logic        o_busy,
  output logic        o_tc
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state;
  logic [3:0]  cnt0, cnt1, cnt2, cnt3;
  logic        b0, b1, b2;
  logic [15:0] period;
  logic        at_one;

  // Borrow flags {b2,b1,b0} for a freshly written value: set where the nibble is zero.
  function automatic logic [2:0] zero_flags(input logic [15:0] v);
    return {v[11:8] == 4'd0, v[7:4] == 4'd0, v[3:0] == 4'd0};
  endfunction

  assign q      = {cnt3, cnt2, cnt1, cnt0};
  assign o_busy = (state == ST_RUN);
  assign at_one = (cnt3 == 4'd0) && (cnt2 == 4'd0) && (cnt1 == 4'd0) && (cnt0 == 4'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {cnt3, cnt2, cnt1, cnt0} <= RESET_VALUE;
      period                   <= RESET_VALUE;
      {b2, b1, b0}             <= zero_flags(RESET_VALUE);
      state                    <= ST_IDLE;
      o_tc                     <= 1'b0;
    end else if (i_load) begin
      {cnt3, cnt2, cnt1, cnt0} <= i_value;
      period                   <= i_value;
      {b2, b1, b0}             <= zero_flags(i_value);
      if (i_value != '0) begin
        state <= ST_RUN;
        o_tc  <= 1'b0;
      end else begin
        state <= ST_IDLE;
        o_tc  <= 1'b1;
      end
    end else if (i_stop) begin
      state <= ST_IDLE;
      o_tc  <= 1'b0;
    end else if ((state == ST_RUN) && i_en) begin
      if (at_one) begin
        o_tc <= 1'b1;
        if (AUTO_RELOAD) begin
          {cnt3, cnt2, cnt1, cnt0} <= period;
          {b2, b1, b0}             <= zero_flags(period);
        end else begin
          {cnt3, cnt2, cnt1, cnt0} <= '0;
          {b2, b1, b0}             <= '1;
          state                    <= ST_IDLE;
        end
      end else begin
        o_tc <= 1'b0;
        // b1/b2 may lag a nibble change by one enabled cycle; they are only
        // consulted when cnt0 reaches 0, at least 15 enabled cycles later.
        cnt0 <= cnt0 - 4'd1;
        if (b0)             cnt1 <= cnt1 - 4'd1;
        if (b0 && b1)       cnt2 <= cnt2 - 4'd1;
        if (b0 && b1 && b2) cnt3 <= cnt3 - 4'd1;
        b0 <= (cnt0 == 4'd1);
        b1 <= (cnt1 == 4'd0);
        b2 <= (cnt2 == 4'd0);
      end
    end else begin
      o_tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_countdown16.sv
// Bench for countdown16: one-shot and auto-reload instances share stimulus and
// are compared every cycle against an integer-arithmetic reference model.
module tb_countdown16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        load  = 1'b0;
  logic        en    = 1'b0;
  logic        stop  = 1'b0;
  logic [15:0] value = '0;

  logic [15:0] q_os, q_ar;
  logic        busy_os, busy_ar, tc_os, tc_ar;

  int checks   = 0;
  int failures = 0;

  int unsigned m_q[2]      = '{0, 0};
  int unsigned m_period[2] = '{0, 0};
  bit          m_busy[2]   = '{0, 0};
  bit          m_tc[2]     = '{0, 0};

  always #5 clk = ~clk;

  countdown16 #(.AUTO_RELOAD(1'b0), .RESET_VALUE(16'h0000)) dut_os (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value(value),
    .i_en(en), .i_stop(stop), .q(q_os), .o_busy(busy_os), .o_tc(tc_os)
  );

  countdown16 #(.AUTO_RELOAD(1'b1), .RESET_VALUE(16'h0000)) dut_ar (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_value(value),
    .i_en(en), .i_stop(stop), .q(q_ar), .o_busy(busy_ar), .o_tc(tc_ar)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: index 0 is one-shot, index 1 is auto-reload.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_q[k] <= 0; m_period[k] <= 0; m_busy[k] <= 1'b0; m_tc[k] <= 1'b0;
      end else if (load) begin
        m_q[k]      <= value;
        m_period[k] <= value;
        m_busy[k]   <= (value != 0);
        m_tc[k]     <= (value == 0);
      end else if (stop) begin
        m_busy[k] <= 1'b0;
        m_tc[k]   <= 1'b0;
      end else if (m_busy[k] && en) begin
        if (m_q[k] == 1) begin
          m_tc[k] <= 1'b1;
          if (k == 1) m_q[k] <= m_period[k];
          else begin
            m_q[k]    <= 0;
            m_busy[k] <= 1'b0;
          end
        end else begin
          m_q[k]  <= m_q[k] - 1;
          m_tc[k] <= 1'b0;
        end
      end else begin
        m_tc[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_q_os",    q_os,    m_q[0]);
      chk("model_busy_os", busy_os, m_busy[0]);
      chk("model_tc_os",   tc_os,   m_tc[0]);
      chk("model_q_ar",    q_ar,    m_q[1]);
      chk("model_busy_ar", busy_ar, m_busy[1]);
      chk("model_tc_ar",   tc_ar,   m_tc[1]);
    end
  end

  initial begin
    int          pulses;
    bit          zero_seen;
    logic [15:0] edges[5] = '{16'h0010, 16'h0100, 16'h1000, 16'h0200, 16'h0011};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_q",    q_os,    32'h0);
    chk("reset_busy", busy_os, 32'h0);
    chk("reset_tc",   tc_os,   32'h0);
    rst_n = 1'b1;

    // Reset mid-run
    load = 1'b1; value = 16'h0100; en = 1'b1; step();
    load = 1'b0;
    repeat (50) step();
    chk("midrun_q_before", q_os, 32'h00CE);
    #2; rst_n = 1'b0; #1;
    chk("midrun_rst_q",       q_os,    32'h0);
    chk("midrun_rst_busy",    busy_os, 32'h0);
    chk("midrun_rst_tc",      tc_os,   32'h0);
    chk("midrun_rst_q_ar",    q_ar,    32'h0);
    chk("midrun_rst_busy_ar", busy_ar, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // One-shot borrow chain
    load = 1'b1; value = 16'h1001; en = 1'b1; step();
    load = 1'b0;
    chk("os_load", q_os, 32'h1001);
    step(); chk("os_e1", q_os, 32'h1000);
    step(); chk("os_e2", q_os, 32'h0FFF);
    step(); chk("os_e3", q_os, 32'h0FFE);
    pulses = 0;
    for (int j = 4; j <= 4096; j++) begin
      step();
      if (tc_os) pulses++;
    end
    chk("os_busy_4096", busy_os, 32'h1);
    step();
    if (tc_os) pulses++;
    chk("os_tc_4097",   tc_os,   32'h1);
    chk("os_q_4097",    q_os,    32'h0);
    chk("os_busy_4097", busy_os, 32'h0);
    step();
    if (tc_os) pulses++;
    chk("os_tc_after", tc_os, 32'h0);
    chk("os_pulses",   pulses, 32'd1);

    // Auto-reload period 5
    load = 1'b1; value = 16'd5; en = 1'b1; step();
    load = 1'b0;
    zero_seen = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (q_ar == 16'd0) zero_seen = 1'b1;
      if (j % 5 == 0) begin
        chk("ar_tc", tc_ar, 32'h1);
        chk("ar_q",  q_ar,  32'd5);
      end else begin
        chk("ar_no_tc", tc_ar, 32'h0);
      end
    end
    chk("ar_never_zero", zero_seen, 32'h0);

    // Enable gaps
    load = 1'b1; value = 16'h0010; en = 1'b0; step();
    load = 1'b0;
    for (int j = 1; j <= 31; j++) begin
      en = (j % 2 == 1);
      step();
      if (j == 1) chk("gap_borrow", q_os, 32'h000F);
      if (j == 2) chk("gap_hold",   q_os, 32'h000F);
      if (j == 30) chk("gap_no_tc_yet", tc_os, 32'h0);
    end
    chk("gap_tc", tc_os, 32'h1);
    chk("gap_q",  q_os,  32'h0);
    en = 1'b0;

    // Load/stop collisions
    load = 1'b1; value = 16'd3; stop = 1'b1; step();
    load = 1'b0; stop = 1'b0;
    chk("ldstop_busy", busy_os, 32'h1);
    chk("ldstop_q",    q_os,    32'd3);
    en = 1'b1; step(); step();
    chk("coll_q1", q_os, 32'd1);
    load = 1'b1; value = 16'd7; step();
    load = 1'b0;
    chk("reload_tc", tc_os, 32'h0);
    chk("reload_q",  q_os,  32'd7);
    repeat (5) step();
    chk("stop_pre_q", q_os, 32'd2);
    stop = 1'b1; step();
    stop = 1'b0;
    chk("stop_busy", busy_os, 32'h0);
    chk("stop_q",    q_os,    32'd2);
    chk("stop_tc",   tc_os,   32'h0);
    step();
    chk("stop_hold_q", q_os, 32'd2);

    // Zero load
    load = 1'b1; value = 16'd0; step();
    load = 1'b0;
    chk("zero_tc",      tc_os,   32'h1);
    chk("zero_busy",    busy_os, 32'h0);
    chk("zero_q",       q_os,    32'h0);
    chk("zero_tc_ar",   tc_ar,   32'h1);
    chk("zero_busy_ar", busy_ar, 32'h0);
    step();
    chk("zero_tc_end", tc_os,   32'h0);
    chk("zero_idle",   busy_os, 32'h0);

    // Randomized traffic, checked each cycle by the model compare process
    for (int n = 0; n < 3000; n++) begin
      load = ($urandom_range(0, 99) < 6);
      case ($urandom_range(0, 3))
        0:       value = 16'($urandom_range(0, 3));
        1:       value = 16'($urandom_range(1, 40));
        2:       value = edges[$urandom_range(0, 4)];
        default: value = 16'($urandom_range(0, 300));
      endcase
      en   = ($urandom_range(0, 3) != 0);
      stop = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown16.md
# countdown16

Loadable 16-bit down counter with terminal-count pulse. It is the counting-down counterpart of the team's nibble-sliced up counters, and generates ultrasonic transmit-delay, gate-width and repetition intervals. The count is held as four 4-bit nibbles with registered borrow flags, so no carry/borrow chain is longer than one nibble plus a 4-input AND. It runs one-shot or auto-reload, and flags zero with a single-cycle pulse.

## Interface
- AUTO_RELOAD, 0: 0 = one-shot (stop at 0); 1 = reload the stored period on every terminal count.
- RESET_VALUE, 16'd0: value of `q` and of the stored period after reset.
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- i_load  input  1  load `i_value` into count and period, and start.
- i_value  input  16  load value (period N).
- i_en  input  1  count enable (clock qualifier); one decrement per enabled cycle.
- i_stop  input  1  abort: return to IDLE, hold `q`, no terminal pulse.
- q  output  16  current count {cnt3,cnt2,cnt1,cnt0}.
- o_busy  output  1  high in RUN state.
- o_tc  output  1  terminal-count pulse, one clock wide.

## Operation
- States:
  - IDLE: `q` holds, `o_busy`=0.
  - RUN: `o_busy`=1.
- Reset (async, any time, including mid-run):
  - `q` = RESET_VALUE, period = RESET_VALUE.
  - State IDLE, `o_tc`=0, `o_busy`=0.
  - Borrow flags b0..b2 set from RESET_VALUE nibbles (bk = nibble k == 0).
- Load (`i_load`=1, any state, independent of `i_en`):
  - `q` <= `i_value`, period <= `i_value`.
  - bk <= (`i_value` nibble k == 0).
  - If `i_value` != 0, state <= RUN, `o_tc` <= 0.
  - If `i_value` == 0, state <= IDLE and `o_tc` <= 1 (immediate terminal count).
- Counting in RUN with `i_en`=1:
  - cnt0 decrements every enabled cycle, wrapping 0 -> F.
  - cnt1 decrements when b0 is set; cnt2 when b0&b1; cnt3 when b0&b1&b2.
  - b0 <= (cnt0 == 1), registered, so it is high exactly while cnt0 == 0.
  - b1 <= (cnt1 == 0); b2 <= (cnt2 == 0).
  - Flags are updated only on enabled cycles, mirroring the up counter's carry pipeline.
- Terminal count, on an enabled RUN cycle with `q` == 1:
  - One-shot: `q` <= 0, `o_tc` <= 1, state <= IDLE, flags set for value 0.
  - Auto-reload: `q` <= period, `o_tc` <= 1, flags reloaded from period, stay in RUN.
  - The q==1 decode may be a registered flag, but its effect must be identical.
- `i_en`=0 in RUN: `q`, the flags and the state hold; `o_tc` <= 0.
- Stop (`i_stop`=1, no `i_load`): state <= IDLE, `q` holds, `o_tc` <= 0.
- Priority: reset > `i_load` > `i_stop` > terminal count > decrement.
- `o_tc` is 0 on every cycle not named above.
- A load in the same cycle as a terminal count suppresses that terminal pulse.

## Timing
- Load sampled at edge k: `q`=N visible after edge k.
- With `i_en` held high, `q`=N-j after edge k+j.
- One-shot: `q`=0 and `o_tc`=1 after edge k+N, `o_busy`=0 from that edge. `o_tc` is back to 0 after edge k+N+1.
- Auto-reload: `o_tc` pulses after edges k+N, k+2N, …, giving period N enabled cycles.
  - At each of these edges `q` shows N, never 0.
  - With N=1, `o_tc` stays high on consecutive enabled cycles; that is the required behaviour.
- Enable gaps stretch every interval by the number of disabled cycles; the count is never skipped.
- Nibble borrow correctness must hold across every boundary: x0 -> (x-1)F, x00 -> (x-1)FF, and 1000 -> 0FFF.
- Load N=0 gives `o_tc`=1 after edge k; the counter never enters RUN.

## Test plan
- Reset mid-run:
  - Stimulus: RESET_VALUE=16'h0000, load 16'h0100, run 50 cycles, pulse `i_rst_n` low between edges.
  - Response: `q`=0, `o_busy`=0, `o_tc`=0 immediately, without waiting for an edge.
- One-shot borrow chain:
  - Stimulus: load 16'h1001, `i_en`=1.
  - Response: `q` sequence 1001, 1000, 0FFF, 0FFE…; `o_tc` pulses exactly once at edge 4097 with `q`=0; `o_busy` falls at the same edge.
- Auto-reload:
  - Stimulus: AUTO_RELOAD=1, load 5, `i_en`=1 for 20 cycles.
  - Response: `q` = 5,4,3,2,1,5,4…; `o_tc` high after edges 5, 10, 15, 20; `q` never 0.
- Enable gaps:
  - Stimulus: load 16'h0010, toggle `i_en` 1/0 each cycle.
  - Response: `o_tc` after the 16th enabled edge (32 clocks); `q` holds on disabled cycles; 10 -> 0F borrow correct.
- Load/stop collisions:
  - Stimulus: load 3 with `i_stop`=1 in the same cycle.
  - Response: RUN with `q`=3.
  - Stimulus: reload 7 on the cycle `q`==1.
  - Response: no `o_tc`, `q`=7.
  - Stimulus: `i_stop` at `q`=2.
  - Response: IDLE, `q`=2 held, no `o_tc`.
- Zero load:
  - Stimulus: load 0.
  - Response: `o_tc` one cycle, `o_busy` stays 0, `q`=0.
